// File: rtl/weight_route_ctrl_if.sv
// Config, router-handshake and select/status bundle of weight_route_ctrl.
// master: cluster control FSM and routers; slave: the sequencing controller.
interface weight_route_ctrl_if #(
  parameter int NR = 3,
  parameter int AW = 8,
  parameter int DW = 12
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NR-1:0] cfg_en;
  logic [NR-1:0] cfg_in_sel;
  logic [NR-1:0] cfg_out_sel;
  logic [AW-1:0] cfg_addr_beats;
  logic [DW-1:0] cfg_data_beats;
  logic          abort;
  logic [NR-1:0] rt_addr_valid;
  logic [NR-1:0] rt_addr_ready;
  logic [NR-1:0] rt_data_valid;
  logic [NR-1:0] rt_data_ready;
  logic [NR-1:0] data_in_sel;
  logic [NR-1:0] data_out_sel;
  logic [NR-1:0] glb_en;
  logic          busy;
  logic          done;
  logic          err_overrun;

  modport master (
    output cfg_valid, cfg_en, cfg_in_sel, cfg_out_sel, cfg_addr_beats, cfg_data_beats,
    output abort, rt_addr_valid, rt_addr_ready, rt_data_valid, rt_data_ready,
    input  cfg_ready, data_in_sel, data_out_sel, glb_en, busy, done, err_overrun
  );

  modport slave (
    input  cfg_valid, cfg_en, cfg_in_sel, cfg_out_sel, cfg_addr_beats, cfg_data_beats,
    input  abort, rt_addr_valid, rt_addr_ready, rt_data_valid, rt_data_ready,
    output cfg_ready, data_in_sel, data_out_sel, glb_en, busy, done, err_overrun
  );
endinterface

// File: rtl/weight_route_ctrl.sv
// Sequences the weight-router selects for one pass and counts addr/data beats per enabled router.
// Latency: selects/busy 1 cycle after cfg accept, glb_en after 2, done 1 cycle after the last beat.
// Backpressure: cfg_ready only while idle; router handshakes are observed, never stalled.
module weight_route_ctrl #(
  parameter int NR = 3,
  parameter int AW = 8,
  parameter int DW = 12
) (
  input logic               clk,
  input logic               rst_n,
  weight_route_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [NR-1:0] en;
    logic [NR-1:0] in_sel;
    logic [NR-1:0] out_sel;
    logic [AW-1:0] addr_beats;
    logic [DW-1:0] data_beats;
  } cfg_t;

  state_t        state;
  cfg_t          cfg_q;
  logic [AW-1:0] addr_cnt    [NR];
  logic [DW-1:0] data_cnt    [NR];
  logic [AW-1:0] addr_cnt_nx [NR];
  logic [DW-1:0] data_cnt_nx [NR];
  logic [NR-1:0] comp_nx;
  logic          overrun;
  logic [NR-1:0] glb_mask;
  logic [NR-1:0] glb_en_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  assign glb_mask = cfg_q.en & ~cfg_q.in_sel;

  // Post-increment counters and completion; beats only count in RUN on enabled routers.
  always_comb begin
    overrun = 1'b0;
    comp_nx = '0;
    for (int i = 0; i < NR; i++) begin
      addr_cnt_nx[i] = addr_cnt[i];
      data_cnt_nx[i] = data_cnt[i];
      if (state == RUN && cfg_q.en[i]) begin
        if (bus.rt_addr_valid[i] && bus.rt_addr_ready[i]) begin
          if (addr_cnt[i] < cfg_q.addr_beats) addr_cnt_nx[i] = addr_cnt[i] + AW'(1);
          else                                overrun = 1'b1;
        end
        if (bus.rt_data_valid[i] && bus.rt_data_ready[i]) begin
          if (data_cnt[i] < cfg_q.data_beats) data_cnt_nx[i] = data_cnt[i] + DW'(1);
          else                                overrun = 1'b1;
        end
      end
      comp_nx[i] = !cfg_q.en[i] ||
                   (addr_cnt_nx[i] == cfg_q.addr_beats && data_cnt_nx[i] == cfg_q.data_beats);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg_q    <= '0;
      glb_en_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        addr_cnt[i] <= '0;
        data_cnt[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        // Cancel keeps the selects so the routers are not disturbed mid-flight.
        state    <= IDLE;
        glb_en_q <= '0;
        busy_q   <= 1'b0;
        for (int i = 0; i < NR; i++) begin
          addr_cnt[i] <= '0;
          data_cnt[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.cfg_valid) begin
              cfg_q  <= '{en: bus.cfg_en, in_sel: bus.cfg_in_sel, out_sel: bus.cfg_out_sel,
                          addr_beats: bus.cfg_addr_beats, data_beats: bus.cfg_data_beats};
              err_q  <= 1'b0;
              busy_q <= 1'b1;
              state  <= SETTLE;
              for (int i = 0; i < NR; i++) begin
                addr_cnt[i] <= '0;
                data_cnt[i] <= '0;
              end
            end
          end
          SETTLE: begin
            state    <= RUN;
            glb_en_q <= glb_mask & ~comp_nx;
          end
          RUN: begin
            for (int i = 0; i < NR; i++) begin
              addr_cnt[i] <= addr_cnt_nx[i];
              data_cnt[i] <= data_cnt_nx[i];
            end
            if (overrun) err_q <= 1'b1;
            if (&comp_nx) begin
              state    <= DONE;
              done_q   <= 1'b1;
              glb_en_q <= '0;
            end else begin
              glb_en_q <= glb_mask & ~comp_nx;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready    = (state == IDLE);
  assign bus.data_in_sel  = cfg_q.in_sel;
  assign bus.data_out_sel = cfg_q.out_sel;
  assign bus.glb_en       = glb_en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overrun  = err_q;
endmodule

// File: tb/tb_weight_route_ctrl.sv
// Directed plus randomized passes for weight_route_ctrl; expected timing comes from
// beat positions in a pre-generated per-cycle handshake stream.
module tb_weight_route_ctrl;
  localparam int NR  = 3;
  localparam int AW  = 8;
  localparam int DW  = 12;
  localparam int LEN = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  weight_route_ctrl_if #(.NR(NR), .AW(AW), .DW(DW)) bus();
  weight_route_ctrl #(.NR(NR), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  bit a_v [NR][LEN];
  bit a_r [NR][LEN];
  bit d_v [NR][LEN];
  bit d_r [NR][LEN];
  int m_ci [NR];
  int done_edge;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_all(input logic v);
    bus.rt_addr_valid = {NR{v}};
    bus.rt_addr_ready = {NR{v}};
    bus.rt_data_valid = {NR{v}};
    bus.rt_data_ready = {NR{v}};
  endtask

  task automatic drive_rand();
    bus.rt_addr_valid = NR'($urandom);
    bus.rt_addr_ready = NR'($urandom);
    bus.rt_data_valid = NR'($urandom);
    bus.rt_data_ready = NR'($urandom);
  endtask

  task automatic idle_inputs();
    bus.cfg_valid      = 1'b0;
    bus.cfg_en         = '0;
    bus.cfg_in_sel     = '0;
    bus.cfg_out_sel    = '0;
    bus.cfg_addr_beats = '0;
    bus.cfg_data_beats = '0;
    bus.abort          = 1'b0;
    drive_all(1'b0);
  endtask

  // Random handshakes with an all-beats tail so every small target is always reached.
  task automatic gen_stream(input bit continuous);
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < LEN; j++) begin
        if (continuous || j >= LEN - 24) begin
          a_v[i][j] = 1'b1; a_r[i][j] = 1'b1; d_v[i][j] = 1'b1; d_r[i][j] = 1'b1;
        end else begin
          a_v[i][j] = ($urandom_range(0, 1) == 1);
          a_r[i][j] = ($urandom_range(0, 3) != 0);
          d_v[i][j] = ($urandom_range(0, 1) == 1);
          d_r[i][j] = ($urandom_range(0, 3) != 0);
        end
      end
  endtask

  function automatic bit beat(input int i, input bit is_addr, input int j);
    return is_addr ? (a_v[i][j] & a_r[i][j]) : (d_v[i][j] & d_r[i][j]);
  endfunction

  // RUN-cycle index of the k-th beat on a stream; -1 when nothing is required.
  function automatic int kth(input int i, input bit is_addr, input int k);
    int seen = 0;
    if (k == 0) return -1;
    for (int j = 0; j < LEN; j++)
      if (beat(i, is_addr, j)) begin
        seen++;
        if (seen == k) return j;
      end
    return LEN;
  endfunction

  // An overrun has happened once an enabled stream saw more beats than its target.
  function automatic bit ovr_upto(input logic [NR-1:0] en, input int at, input int dt, input int j);
    for (int i = 0; i < NR; i++) begin
      int na = 0;
      int nd = 0;
      if (!en[i]) continue;
      for (int k = 0; k <= j; k++) begin
        if (beat(i, 1'b1, k)) na++;
        if (beat(i, 1'b0, k)) nd++;
      end
      if (na > at || nd > dt) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] glb_at(input logic [NR-1:0] en, input logic [NR-1:0] in_s, input int m);
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = en[i] & ~in_s[i] & (m_ci[i] >= m);
    return r;
  endfunction

  task automatic drive_run(input int j);
    logic [NR-1:0] av, ar, dv, dr;
    for (int i = 0; i < NR; i++) begin
      av[i] = a_v[i][j]; ar[i] = a_r[i][j]; dv[i] = d_v[i][j]; dr[i] = d_r[i][j];
    end
    bus.rt_addr_valid = av;
    bus.rt_addr_ready = ar;
    bus.rt_data_valid = dv;
    bus.rt_data_ready = dr;
  endtask

  task automatic run_pass(input logic [NR-1:0] en, input logic [NR-1:0] in_s, input logic [NR-1:0] out_s,
                          input int at, input int dt, input int abort_at, input bit abort_cfg,
                          input string nm);
    int  c = 0;
    bit  aborted = 1'b0;
    for (int i = 0; i < NR; i++) begin
      int ka = kth(i, 1'b1, at);
      int kd = kth(i, 1'b0, dt);
      m_ci[i] = (ka > kd) ? ka : kd;
      if (en[i] && m_ci[i] > c) c = m_ci[i];
    end
    done_edge = -1;
    bus.cfg_en = en; bus.cfg_in_sel = in_s; bus.cfg_out_sel = out_s;
    bus.cfg_addr_beats = AW'(at); bus.cfg_data_beats = DW'(dt);
    bus.cfg_valid = 1'b1;
    bus.abort = abort_cfg;
    chk({nm, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_en = ~en; bus.cfg_in_sel = ~in_s; bus.cfg_out_sel = ~out_s;
    bus.cfg_addr_beats = AW'($urandom); bus.cfg_data_beats = DW'($urandom);
    chk({nm, "_settle_busy"}, 32'(bus.busy), 32'd1);
    chk({nm, "_settle_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
    chk({nm, "_in_sel"}, 32'(bus.data_in_sel), 32'(in_s));
    chk({nm, "_out_sel"}, 32'(bus.data_out_sel), 32'(out_s));
    chk({nm, "_settle_glb"}, 32'(bus.glb_en), 32'd0);
    chk({nm, "_err_cleared"}, 32'(bus.err_overrun), 32'd0);
    drive_all(1'b1);
    tick();
    chk({nm, "_run0_glb"}, 32'(bus.glb_en), 32'(glb_at(en, in_s, 0)));
    for (int j = 0; j < LEN; j++) begin
      drive_run(j);
      bus.abort = (j == abort_at);
      tick();
      bus.abort = 1'b0;
      if (bus.done) done_edge = j + 2;
      if (j == abort_at) begin
        aborted = 1'b1;
        chk({nm, "_abort_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_abort_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_abort_glb"}, 32'(bus.glb_en), 32'd0);
        chk({nm, "_abort_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        chk({nm, "_abort_in_sel"}, 32'(bus.data_in_sel), 32'(in_s));
        chk({nm, "_abort_out_sel"}, 32'(bus.data_out_sel), 32'(out_s));
        break;
      end
      if (j == c) begin
        chk({nm, "_done"}, 32'(bus.done), 32'd1);
        chk({nm, "_done_glb"}, 32'(bus.glb_en), 32'd0);
        chk({nm, "_done_busy"}, 32'(bus.busy), 32'd1);
        chk({nm, "_done_err"}, 32'(bus.err_overrun), 32'(ovr_upto(en, at, dt, j)));
        break;
      end
      chk({nm, "_run_done"}, 32'(bus.done), 32'd0);
      chk({nm, "_run_glb"}, 32'(bus.glb_en), 32'(glb_at(en, in_s, j + 1)));
      chk({nm, "_run_err"}, 32'(bus.err_overrun), 32'(ovr_upto(en, at, dt, j)));
    end
    if (aborted) begin
      drive_rand();
      for (int k = 0; k < 4; k++) begin
        tick();
        chk({nm, "_post_abort_done"}, 32'(bus.done), 32'd0);
      end
    end else begin
      drive_rand();
      tick();
      chk({nm, "_idle_done"}, 32'(bus.done), 32'd0);
      chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_idle_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
      chk({nm, "_idle_in_sel"}, 32'(bus.data_in_sel), 32'(in_s));
      chk({nm, "_idle_out_sel"}, 32'(bus.data_out_sel), 32'(out_s));
      chk({nm, "_idle_err"}, 32'(bus.err_overrun), 32'(ovr_upto(en, at, dt, c)));
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_in_sel", 32'(bus.data_in_sel), 32'd0);
    chk("rst_out_sel", 32'(bus.data_out_sel), 32'd0);
    chk("rst_glb", 32'(bus.glb_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err_overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // All routers, GLB in, 4 addr / 9 data beats, handshakes every cycle.
    gen_stream(1'b1);
    run_pass(3'b111, 3'b000, 3'b000, 4, 9, -1, 1'b0, "t_full");
    chk("t_full_done_cycle", 32'(done_edge + 1), 32'd11);

    // Router 2 disabled but flooded with beats; router 1 fed horizontally.
    gen_stream(1'b0);
    for (int j = 0; j < LEN; j++) begin
      a_v[2][j] = 1'b1; a_r[2][j] = 1'b1; d_v[2][j] = 1'b1; d_r[2][j] = 1'b1;
    end
    run_pass(3'b011, 3'b010, 3'b001, 3, 5, -1, 1'b0, "t_mask");

    // Router 0 gets 5 address beats against a target of 4.
    gen_stream(1'b1);
    for (int j = 5; j < LEN; j++) a_v[0][j] = 1'b0;
    run_pass(3'b001, 3'b000, 3'b000, 4, 9, -1, 1'b0, "t_ovr");
    chk("t_ovr_sticky", 32'(bus.err_overrun), 32'd1);

    // Zero targets: the next acceptance also clears the overrun flag.
    gen_stream(1'b0);
    run_pass(3'b111, 3'b101, 3'b010, 0, 0, -1, 1'b0, "t_zero");
    chk("t_zero_done_cycle", 32'(done_edge + 1), 32'd3);

    // Abort after 2 of 4 beats, then a fresh pass accepted with abort held in IDLE.
    gen_stream(1'b1);
    run_pass(3'b001, 3'b000, 3'b001, 4, 4, 2, 1'b0, "t_abort");
    run_pass(3'b001, 3'b000, 3'b001, 4, 4, -1, 1'b1, "t_restart");
    chk("t_restart_done_cycle", 32'(done_edge + 1), 32'd6);

    for (int p = 0; p < 25; p++) begin
      logic [NR-1:0] en, in_s, out_s;
      int at, dt, ab;
      en    = NR'($urandom_range(0, 7));
      in_s  = NR'($urandom_range(0, 7));
      out_s = NR'($urandom_range(0, 7));
      at    = $urandom_range(0, 5);
      dt    = $urandom_range(0, 8);
      ab    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      gen_stream(1'b0);
      run_pass(en, in_s, out_s, at, dt, ab, 1'b0, "t_rand");
    end

    // Asynchronous reset while a pass is running.
    bus.cfg_en = 3'b111; bus.cfg_in_sel = 3'b101; bus.cfg_out_sel = 3'b110;
    bus.cfg_addr_beats = 8'd5; bus.cfg_data_beats = 12'd5;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    drive_all(1'b1);
    tick();
    tick();
    tick();
    chk("t_rst_pre_glb", 32'(bus.glb_en), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t_rst_busy", 32'(bus.busy), 32'd0);
    chk("t_rst_glb", 32'(bus.glb_en), 32'd0);
    chk("t_rst_done", 32'(bus.done), 32'd0);
    chk("t_rst_in_sel", 32'(bus.data_in_sel), 32'd0);
    chk("t_rst_out_sel", 32'(bus.data_out_sel), 32'd0);
    chk("t_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t_rst_no_done", 32'(bus.done), 32'd0);
    end
    chk("t_rst_idle_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/weight_route_ctrl.md
# weight_route_ctrl

Sequencing controller for the three weight routers of one router cluster. It accepts a per-pass routing configuration and drives the routers' `data_in_sel`/`data_out_sel` selects. It holds those selects stable while it counts address and data beats on each router's selected input. It releases the configuration with a `done` pulse once every enabled router has carried its programmed packet. It sits between the cluster's top-level control FSM and the three weight routers, and it enables GLB weight ports only while a pass is running.

## Interface
Parameters:
- `NR`, 3: number of weight routers, one per PE row.
- `AW`, 8: width of the address beat counter.
- `DW`, 12: width of the data beat counter.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration accepted when high with `cfg_valid`.
- `cfg_en` in NR: routers taking part in the pass.
- `cfg_in_sel` in NR: per router, 0 = GLB, 1 = HORIZ.
- `cfg_out_sel` in NR: per router, 0 = UNICAST, 1 = HOR_CAST.
- `cfg_addr_beats` in AW: address beats per enabled router.
- `cfg_data_beats` in DW: data beats per enabled router.
- `abort` in 1: synchronous cancel of the current pass.
- `rt_addr_valid`, `rt_addr_ready` in NR: handshake of each router's selected address input.
- `rt_data_valid`, `rt_data_ready` in NR: handshake of each router's selected data input.
- `data_in_sel` out NR: to routers, registered.
- `data_out_sel` out NR: to routers, registered.
- `glb_en` out NR: GLB weight port may issue.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle completion pulse.
- `err_overrun` out 1: sticky flag, set by a beat beyond the programmed count.

## Operation
- The FSM states are IDLE, SETTLE, RUN and DONE.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`, the controller latches `cfg_en`, both select vectors and both beat counts, clears all counters, and goes to SETTLE.
- SETTLE:
  - Lasts exactly one cycle, so that router muxes and neighbours see the new selects before traffic starts. The next state is RUN.
- RUN:
  - Per router i with `en[i]`=1: an address beat is `rt_addr_valid[i]&rt_addr_ready[i]`, and a data beat is `rt_data_valid[i]&rt_data_ready[i]`.
  - Each beat increments the matching counter while that counter is below its target.
  - A beat arriving when the counter already equals its target is not counted and sets `err_overrun`.
  - Beats on routers with `en[i]`=0 are ignored and never set an error.
  - Router i is complete when `en[i]`=0, or when both of its counters equal their targets.
  - When all routers are complete (evaluated on post-increment values), the next state is DONE.
  - A target of 0 means that stream is complete immediately, so all-zero targets give RUN for one cycle.
- DONE:
  - `done`=1 for one cycle, then the FSM returns to IDLE.
- Selects:
  - `data_in_sel` and `data_out_sel` update only on the cycle after config acceptance.
  - They hold their values through SETTLE, RUN, DONE and the following IDLE, until the next configuration.
- `glb_en[i]` is 1 when all of the following hold:
  - state is RUN,
  - `en[i]`=1,
  - `in_sel[i]`=GLB,
  - router i is not complete.
- `busy` is 1 in SETTLE, RUN and DONE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE, counters clear, and `done` is not raised.
  - Selects are kept.
  - `abort` in IDLE is ignored, and `abort` together with `cfg_valid` in IDLE accepts the config.
- If `abort` arrives in the same cycle as final completion, abort wins and no `done` is raised.
- `err_overrun` clears only on reset or on the next config acceptance.

## Timing
- Reset values:
  - state IDLE, `cfg_ready`=1,
  - `data_in_sel`=0, `data_out_sel`=0,
  - `glb_en`=0, `busy`=0, `done`=0, `err_overrun`=0,
  - all counters 0.
- Config accepted at edge T:
  - Selects and `busy` are valid at T+1 (SETTLE).
  - `glb_en` rises at T+2 (RUN).
  - The first counted beat is at T+2.
- Last beat counted at edge L: `done`=1 during L+1, and `cfg_ready`=1 from L+2.
- Minimum pass with zero targets: `done` appears 3 cycles after acceptance.
- `glb_en[i]` drops the cycle after router i reaches both targets.
- All outputs are registered except `cfg_ready`, which is a decode of the state register.

## Test plan
- Reset mid-RUN with `rst_n` low → all outputs take their reset values immediately, and there is no `done` after release.
- Config en=3'b111, in_sel=000, out_sel=000, addr=4, data=9 on all routers, with continuous handshakes from T+2 → `done` at T+11, and `glb_en` low from T+11.
- Config en=3'b011, in_sel=3'b010, out_sel=3'b001 → selects equal 010/001 at T+1, `glb_en`=3'b001 in RUN, and router 2 beats are ignored.
- Router 0 gets 5 address beats with target 4 → `err_overrun`=1 and stays 1 through `done`; the next config clears it.
- `abort` in RUN after 2 of 4 beats → IDLE next cycle, no `done`, selects unchanged, and a new config then restarts with counters at 0.
- Zero targets on all routers → SETTLE, RUN, DONE, with a `done` pulse 3 cycles after acceptance.
